// File: rtl/gen_cond_op_pipe.sv
// Multi-lane datapath whose per-lane op is fixed at elaboration by a generate-if chain,
// with optional per-lane accumulation, a valid/ready register pipeline and a transfer counter.
module gen_cond_op_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned K      = 1,
  parameter int unsigned MASK   = 32'hF0,
  parameter int unsigned ACC_EN = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [15:0]            xfer_count
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam logic [WIDTH-1:0] KW    = WIDTH'(K);
  localparam logic [WIDTH-1:0] MaskW = WIDTH'(MASK);

  logic [STAGES-1:0] v_q;
  logic [DW-1:0]     d_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [DW-1:0]     load_data;
  logic              accept;
  logic [15:0]       xfer_q;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      adv[i] = !v_q[i] || adv[i+1];
    end
  end

  assign in_ready = rst_n && adv[0];
  assign accept   = in_valid && in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    assign x = in_data[l*WIDTH +: WIDTH];

    if (MODE == 0) begin : g_add
      assign y = x + KW;
    end else if ((MODE == 1) && (WIDTH > 1)) begin : g_dbl
      assign y = {x[WIDTH-2:0], 1'b0};
    end else if ((MODE % 4 == 2) && (MODE < 4)) begin : g_and
      assign y = x & MaskW;
    end else if (MODE * 2 == 6) begin : g_xor
      assign y = x ^ MaskW;
    end else begin : g_pass
      assign y = x;
    end

    if (ACC_EN != 0) begin : g_acc
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] acc_sum;

      // A clear in the accept cycle makes this beat start from zero.
      assign acc_sum = (clear ? '0 : acc_q) + y;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else if (accept) begin
          acc_q <= acc_sum;
        end else if (clear) begin
          acc_q <= '0;
        end
      end

      assign load_data[l*WIDTH +: WIDTH] = acc_sum;
    end else begin : g_noacc
      assign load_data[l*WIDTH +: WIDTH] = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        d_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_q[0] <= accept;
        if (accept) begin
          d_q[0] <= load_data;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (adv[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            d_q[i] <= d_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q <= '0;
    end else if (clear) begin
      xfer_q <= accept ? 16'd1 : 16'd0;
    end else if (accept) begin
      xfer_q <= xfer_q + 16'd1;
    end
  end

  assign out_valid  = v_q[STAGES-1];
  assign out_data   = d_q[STAGES-1];
  assign xfer_count = xfer_q;

endmodule
